// File: rtl/traffic_pkg.sv
// Shared types and codes for the traffic-light controller: state encoding,
// lamp codes, interval-select codes and the state-to-lamp decode.
package traffic_pkg;

   typedef enum logic [2:0] {
      S_MG1    = 3'd0,
      S_MG2    = 3'd1,
      S_MY     = 3'd2,
      S_WALK   = 3'd3,
      S_SG     = 3'd4,
      S_SG_EXT = 3'd5,
      S_SY     = 3'd6
   } state_e;

   localparam logic [2:0] LAMP_R = 3'b100;
   localparam logic [2:0] LAMP_Y = 3'b010;
   localparam logic [2:0] LAMP_G = 3'b001;

   localparam logic [1:0] SEL_BASE = 2'b00;
   localparam logic [1:0] SEL_EXT  = 2'b01;
   localparam logic [1:0] SEL_YEL  = 2'b10;

   typedef struct packed {
      logic [2:0] main;
      logic [2:0] side;
      logic       walk;
   } lamps_t;

   // Steady lamp pattern of each state; the walk lamp is shaped further by the top.
   function automatic lamps_t state_lamps(input state_e s);
      lamps_t l;
      l = '{main: LAMP_R, side: LAMP_R, walk: 1'b0};
      case (s)
         S_MG1, S_MG2:    l.main = LAMP_G;
         S_MY:            l.main = LAMP_Y;
         S_WALK:          l.walk = 1'b1;
         S_SG, S_SG_EXT:  l.side = LAMP_G;
         S_SY:            l.side = LAMP_Y;
         default:         l.main = LAMP_G;
      endcase
      return l;
   endfunction

endpackage

// File: rtl/interval_timer.sv
// Dwell timer: prescaler of CLK_PER_SEC cycles feeding a seconds down-counter.
// With WALK_BLINK_EN defined, also provides half_sec for the walk-lamp blink.
module interval_timer #(
   parameter int unsigned CLK_PER_SEC = 100,
   parameter int unsigned TW          = 4,
   parameter int unsigned RST_VAL     = 6
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          load,
   input  logic [TW-1:0] value,
`ifdef WALK_BLINK_EN
   output logic          half_sec,
`endif
   output logic          expired
);

   localparam int unsigned PW = (CLK_PER_SEC > 1) ? $clog2(CLK_PER_SEC) : 1;
   localparam logic [PW-1:0] PRE_LAST = PW'(CLK_PER_SEC - 1);
   localparam logic [TW-1:0] RST_SEC  = (RST_VAL == 0) ? TW'(1) : TW'(RST_VAL);

   logic [PW-1:0] pre_q, pre_d;
   logic [TW-1:0] sec_q, sec_d;

   // A zero interval would never expire, so it runs as one second.
   function automatic logic [TW-1:0] clamp_sec(input logic [TW-1:0] v);
      return (v == '0) ? TW'(1) : v;
   endfunction

   always_comb begin
      pre_d = pre_q;
      sec_d = sec_q;
      if (load) begin
         pre_d = '0;
         sec_d = clamp_sec(value);
      end else if (pre_q == PRE_LAST) begin
         pre_d = '0;
         sec_d = sec_q - TW'(1);
      end else begin
         pre_d = pre_q + PW'(1);
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         pre_q <= '0;
         sec_q <= RST_SEC;
      end else begin
         pre_q <= pre_d;
         sec_q <= sec_d;
      end
   end

   assign expired = (sec_q == TW'(1)) && (pre_q == PRE_LAST);

`ifdef WALK_BLINK_EN
   localparam logic [PW-1:0] PRE_HALF = PW'(CLK_PER_SEC / 2);
   // Low only during the first half of the final second, high otherwise.
   assign half_sec = !((sec_q == TW'(1)) && (pre_q < PRE_HALF));
`endif

endmodule

// File: rtl/traffic_light_fsm.sv
// Main/side street traffic-light controller with pedestrian walk phase and
// programmable intervals. Optional walk-lamp blink: define WALK_BLINK_EN.
module traffic_light_fsm
   import traffic_pkg::*;
#(
   parameter int unsigned CLK_PER_SEC = 100,
   parameter int unsigned TW          = 4,
   parameter int unsigned T_BASE      = 6,
   parameter int unsigned T_EXT       = 3,
   parameter int unsigned T_YEL       = 2
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          sensor_sync,
   input  logic          wr_sync,
   input  logic          prog_sync,
   input  logic [1:0]    time_sel,
   input  logic [TW-1:0] time_value,
   output logic [2:0]    main_light,
   output logic [2:0]    side_light,
   output logic          walk_light
);

   state_e        state_q, state_d;
   logic [TW-1:0] base_q, base_d;
   logic [TW-1:0] ext_q, ext_d;
   logic [TW-1:0] yel_q, yel_d;
   logic          walk_pend_q, walk_pend_d;
   logic          tmr_load_c;
   logic [TW-1:0] tmr_val_c;
   logic          expired_c;
   lamps_t        lamps_c;

   // Interval registers written by the reprogram strobe.
   always_comb begin
      base_d = base_q;
      ext_d  = ext_q;
      yel_d  = yel_q;
      if (prog_sync) begin
         case (time_sel)
            SEL_BASE: base_d = time_value;
            SEL_EXT:  ext_d  = time_value;
            SEL_YEL:  yel_d  = time_value;
            default:  ;
         endcase
      end
   end

   // Next state, timer reload and walk request bookkeeping.
   always_comb begin
      state_d     = state_q;
      tmr_load_c  = 1'b0;
      tmr_val_c   = base_q;
      walk_pend_d = walk_pend_q;
      if (prog_sync) begin
         state_d    = S_MG1;
         tmr_load_c = 1'b1;
         tmr_val_c  = base_d;
      end else if (expired_c) begin
         tmr_load_c = 1'b1;
         case (state_q)
            S_MG1: begin
               state_d   = S_MG2;
               tmr_val_c = sensor_sync ? ext_q : base_q;
            end
            S_MG2: begin
               state_d   = S_MY;
               tmr_val_c = yel_q;
            end
            S_MY: begin
               state_d   = walk_pend_q ? S_WALK : S_SG;
               tmr_val_c = walk_pend_q ? ext_q : base_q;
            end
            S_WALK: begin
               state_d     = S_SG;
               tmr_val_c   = base_q;
               walk_pend_d = 1'b0;
            end
            S_SG: begin
               state_d   = sensor_sync ? S_SG_EXT : S_SY;
               tmr_val_c = sensor_sync ? ext_q : yel_q;
            end
            S_SG_EXT: begin
               state_d   = S_SY;
               tmr_val_c = yel_q;
            end
            S_SY: begin
               state_d   = S_MG1;
               tmr_val_c = base_q;
            end
            default: begin
               state_d   = S_MG1;
               tmr_val_c = base_q;
            end
         endcase
      end
      // A request made while walking is already being served.
      if (wr_sync && (state_q != S_WALK)) begin
         walk_pend_d = 1'b1;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q     <= S_MG1;
         base_q      <= TW'(T_BASE);
         ext_q       <= TW'(T_EXT);
         yel_q       <= TW'(T_YEL);
         walk_pend_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         base_q      <= base_d;
         ext_q       <= ext_d;
         yel_q       <= yel_d;
         walk_pend_q <= walk_pend_d;
      end
   end

`ifdef WALK_BLINK_EN
   logic blink_c;

   interval_timer #(
      .CLK_PER_SEC (CLK_PER_SEC),
      .TW          (TW),
      .RST_VAL     (T_BASE)
   ) u_timer (
      .clock    (clock),
      .reset    (reset),
      .load     (tmr_load_c),
      .value    (tmr_val_c),
      .half_sec (blink_c),
      .expired  (expired_c)
   );
`else
   interval_timer #(
      .CLK_PER_SEC (CLK_PER_SEC),
      .TW          (TW),
      .RST_VAL     (T_BASE)
   ) u_timer (
      .clock   (clock),
      .reset   (reset),
      .load    (tmr_load_c),
      .value   (tmr_val_c),
      .expired (expired_c)
   );
`endif

   // Lamps follow the state register with no added latency.
   always_comb begin
      lamps_c = state_lamps(state_q);
`ifdef WALK_BLINK_EN
      if (state_q == S_WALK) begin
         lamps_c.walk = blink_c;
      end
`endif
   end

   assign main_light = lamps_c.main;
   assign side_light = lamps_c.side;
   assign walk_light = lamps_c.walk;

endmodule

// File: tb/tb_traffic_light_fsm.sv
// Self-checking bench for traffic_light_fsm: directed phase-length scenarios
// plus randomized traffic compared against a cycles-remaining phase model.
module tb_traffic_light_fsm;

   localparam int CPS = 4;
   localparam int TW  = 4;

   localparam int PH_MG1 = 0, PH_MG2 = 1, PH_MY = 2, PH_WALK = 3,
                  PH_SG = 4, PH_SGX = 5, PH_SY = 6;

   localparam logic [6:0] MAIN_MASK = 7'b111_000_0;
   localparam logic [6:0] MAIN_G    = 7'b001_000_0;
   localparam logic [6:0] MAIN_Y    = 7'b010_000_0;
   localparam logic [6:0] SIDE_MASK = 7'b000_111_0;
   localparam logic [6:0] SIDE_G    = 7'b000_001_0;
   localparam logic [6:0] SIDE_Y    = 7'b000_010_0;
   localparam logic [6:0] WALK_MASK = 7'b111_111_0;
   localparam logic [6:0] WALK_PAT  = 7'b100_100_0;
   localparam logic [6:0] L_MG      = 7'b001_100_0;
   localparam logic [6:0] L_SG      = 7'b100_001_0;
   localparam logic [6:0] L_WALK    = 7'b100_100_1;

   logic          clock = 1'b0;
   logic          reset = 1'b0;
   logic          sensor_sync = 1'b0;
   logic          wr_sync = 1'b0;
   logic          prog_sync = 1'b0;
   logic [1:0]    time_sel = 2'b00;
   logic [TW-1:0] time_value = '0;
   logic [2:0]    main_light, side_light;
   logic          walk_light;

   int checks = 0;
   int errors = 0;

   int m_ph, m_rem, m_base, m_ext, m_yel;
   bit m_pend;

   traffic_light_fsm #(.CLK_PER_SEC(CPS), .TW(TW)) dut (
      .clock       (clock),
      .reset       (reset),
      .sensor_sync (sensor_sync),
      .wr_sync     (wr_sync),
      .prog_sync   (prog_sync),
      .time_sel    (time_sel),
      .time_value  (time_value),
      .main_light  (main_light),
      .side_light  (side_light),
      .walk_light  (walk_light)
   );

   always #5 clock = ~clock;

   function automatic int secs(input int v);
      return (v == 0) ? 1 : v;
   endfunction

   function automatic logic [6:0] lamps();
      return {main_light, side_light, walk_light};
   endfunction

   function automatic logic [6:0] model_lamps();
      logic w;
      case (m_ph)
         PH_MG1, PH_MG2: return L_MG;
         PH_MY:          return 7'b010_100_0;
         PH_WALK: begin
            w = 1'b1;
`ifdef WALK_BLINK_EN
            if (m_rem <= CPS) w = (m_rem <= CPS / 2);
`endif
            return {6'b100_100, w};
         end
         PH_SG, PH_SGX:  return L_SG;
         default:        return 7'b100_010_0;
      endcase
   endfunction

   task automatic model_reset();
      m_ph = PH_MG1; m_base = 6; m_ext = 3; m_yel = 2; m_pend = 0;
      m_rem = m_base * CPS;
   endtask

   // One clock edge of the controller as the rules describe it.
   task automatic model_edge();
      int old_ph;
      int d;
      old_ph = m_ph;
      if (prog_sync) begin
         case (time_sel)
            2'd0: m_base = int'(time_value);
            2'd1: m_ext  = int'(time_value);
            2'd2: m_yel  = int'(time_value);
            default: ;
         endcase
         m_ph  = PH_MG1;
         m_rem = secs(m_base) * CPS;
      end else begin
         m_rem--;
         if (m_rem == 0) begin
            case (old_ph)
               PH_MG1:  begin m_ph = PH_MG2; d = sensor_sync ? m_ext : m_base; end
               PH_MG2:  begin m_ph = PH_MY;  d = m_yel; end
               PH_MY:   begin m_ph = m_pend ? PH_WALK : PH_SG; d = m_pend ? m_ext : m_base; end
               PH_WALK: begin m_ph = PH_SG;  d = m_base; m_pend = 0; end
               PH_SG:   begin m_ph = sensor_sync ? PH_SGX : PH_SY; d = sensor_sync ? m_ext : m_yel; end
               PH_SGX:  begin m_ph = PH_SY;  d = m_yel; end
               default: begin m_ph = PH_MG1; d = m_base; end
            endcase
            m_rem = secs(d) * CPS;
         end
      end
      if (wr_sync && old_ph != PH_WALK) m_pend = 1;
   endtask

   task automatic step();
      @(posedge clock);
      model_edge();
      #1;
   endtask

   task automatic restart();
      reset = 1'b0;
      model_reset();
      #1;
      reset = 1'b1;
   endtask

   // Advance while the masked lamps match pat; n = edges taken, bad = model disagreements.
   task automatic run_while(input logic [6:0] mask, input logic [6:0] pat,
                            output int n, output int bad);
      n = 0; bad = 0;
      while (((lamps() & mask) == pat) && n < 400) begin
         step();
         n++;
         if (lamps() !== model_lamps()) bad++;
      end
   endtask

   task automatic test_reset();
      reset = 1'b0;
      model_reset();
      repeat (3) @(posedge clock);
      #1;
      checks++;
      if (lamps() !== L_MG) begin
         errors++;
         $display("FAIL reset_lamps got %b exp %b", lamps(), L_MG);
      end
      reset = 1'b1;
   endtask

   task automatic test_idle();
      int n, b, bad;
      int got[4];
      int exp_n[4] = '{48, 8, 24, 8};
      restart();
      bad = 0;
      run_while(MAIN_MASK, MAIN_G, got[0], b); bad += b;
      run_while(MAIN_MASK, MAIN_Y, got[1], b); bad += b;
      run_while(SIDE_MASK, SIDE_G, got[2], b); bad += b;
      run_while(SIDE_MASK, SIDE_Y, got[3], b); bad += b;
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (got[i] !== exp_n[i]) begin
            errors++;
            $display("FAIL idle_phase%0d cycles got %0d exp %0d", i, got[i], exp_n[i]);
         end
      end
      checks++;
      if (lamps() !== L_MG) begin
         errors++;
         $display("FAIL idle_back_mg1 got %b exp %b", lamps(), L_MG);
      end
      n = bad;
      checks++;
      if (n !== 0) begin
         errors++;
         $display("FAIL idle_model disagreements got %0d exp 0", n);
      end
   endtask

   task automatic test_sensor();
      int n, b, bad;
      restart();
      bad = 0;
      repeat (20) step();
      sensor_sync = 1'b1;
      run_while(MAIN_MASK, MAIN_G, n, b); bad += b;
      checks++;
      if (n + 20 !== 36) begin
         errors++;
         $display("FAIL sensor_main_green got %0d exp 36", n + 20);
      end
      run_while(MAIN_MASK, MAIN_Y, n, b); bad += b;
      run_while(SIDE_MASK, SIDE_G, n, b); bad += b;
      checks++;
      if (n !== 36) begin
         errors++;
         $display("FAIL sensor_side_green got %0d exp 36", n);
      end
      run_while(SIDE_MASK, SIDE_Y, n, b); bad += b;
      checks++;
      if (n !== 8) begin
         errors++;
         $display("FAIL sensor_side_yellow got %0d exp 8", n);
      end
      sensor_sync = 1'b0;
      checks++;
      if (bad !== 0) begin
         errors++;
         $display("FAIL sensor_model disagreements got %0d exp 0", bad);
      end
   endtask

   task automatic test_walk();
      int n, b, bad;
      restart();
      bad = 0;
      repeat (3) step();
      wr_sync = 1'b1; step(); wr_sync = 1'b0;
      run_while(MAIN_MASK, MAIN_G, n, b); bad += b;
      run_while(MAIN_MASK, MAIN_Y, n, b); bad += b;
      checks++;
      if (lamps() !== L_WALK) begin
         errors++;
         $display("FAIL walk_entry got %b exp %b", lamps(), L_WALK);
      end
      repeat (4) step();
      wr_sync = 1'b1; step(); wr_sync = 1'b0;
      run_while(WALK_MASK, WALK_PAT, n, b); bad += b;
      checks++;
      if (n + 5 !== 12) begin
         errors++;
         $display("FAIL walk_dwell got %0d exp 12", n + 5);
      end
      checks++;
      if (lamps() !== L_SG) begin
         errors++;
         $display("FAIL walk_then_sg got %b exp %b", lamps(), L_SG);
      end
      run_while(SIDE_MASK, SIDE_G, n, b); bad += b;
      run_while(SIDE_MASK, SIDE_Y, n, b); bad += b;
      run_while(MAIN_MASK, MAIN_G, n, b); bad += b;
      run_while(MAIN_MASK, MAIN_Y, n, b); bad += b;
      checks++;
      if (lamps() !== L_SG) begin
         errors++;
         $display("FAIL no_second_walk got %b exp %b", lamps(), L_SG);
      end
      checks++;
      if (bad !== 0) begin
         errors++;
         $display("FAIL walk_model disagreements got %0d exp 0", bad);
      end
   endtask

   task automatic test_prog();
      int n, b;
      restart();
      run_while(MAIN_MASK, MAIN_G, n, b);
      run_while(MAIN_MASK, MAIN_Y, n, b);
      repeat (5) step();
      prog_sync = 1'b1; time_sel = 2'b00; time_value = 4'd2;
      step();
      prog_sync = 1'b0;
      checks++;
      if (lamps() !== L_MG) begin
         errors++;
         $display("FAIL prog_forces_mg1 got %b exp %b", lamps(), L_MG);
      end
      run_while(MAIN_MASK, MAIN_G, n, b);
      checks++;
      if (n !== 16) begin
         errors++;
         $display("FAIL prog_base2_green got %0d exp 16", n);
      end
      prog_sync = 1'b1; time_sel = 2'b01; time_value = 4'd0;
      sensor_sync = 1'b1;
      step();
      prog_sync = 1'b0;
      run_while(MAIN_MASK, MAIN_G, n, b);
      checks++;
      if (n !== 12) begin
         errors++;
         $display("FAIL prog_ext0_green got %0d exp 12", n);
      end
      sensor_sync = 1'b0;
   endtask

   task automatic test_prog_none();
      int n, b, bad;
      restart();
      bad = 0;
      repeat (10) step();
      prog_sync = 1'b1; time_sel = 2'b11; time_value = 4'd9;
      step();
      prog_sync = 1'b0;
      run_while(MAIN_MASK, MAIN_G, n, b); bad += b;
      checks++;
      if (n !== 48) begin
         errors++;
         $display("FAIL sel11_green got %0d exp 48", n);
      end
      run_while(MAIN_MASK, MAIN_Y, n, b); bad += b;
      checks++;
      if (n !== 8) begin
         errors++;
         $display("FAIL sel11_yellow got %0d exp 8", n);
      end
      restart();
      run_while(MAIN_MASK, MAIN_G, n, b);
      repeat (7) step();
      prog_sync = 1'b1; time_sel = 2'b11;
      step();
      prog_sync = 1'b0;
      checks++;
      if (lamps() !== L_MG) begin
         errors++;
         $display("FAIL prog_over_expiry got %b exp %b", lamps(), L_MG);
      end
      checks++;
      if (bad !== 0) begin
         errors++;
         $display("FAIL sel11_model disagreements got %0d exp 0", bad);
      end
   endtask

   task automatic test_reset_mid();
      int n, b;
      restart();
      prog_sync = 1'b1; time_sel = 2'b00; time_value = 4'd9;
      step();
      prog_sync = 1'b0;
      sensor_sync = 1'b1;
      run_while(MAIN_MASK, MAIN_G, n, b);
      checks++;
      if (n !== 48) begin
         errors++;
         $display("FAIL base9_green got %0d exp 48", n);
      end
      run_while(MAIN_MASK, MAIN_Y, n, b);
      repeat (39) step();
      checks++;
      if (lamps() !== L_SG) begin
         errors++;
         $display("FAIL in_sg_ext got %b exp %b", lamps(), L_SG);
      end
      reset = 1'b0;
      model_reset();
      #1;
      checks++;
      if (lamps() !== L_MG) begin
         errors++;
         $display("FAIL reset_async got %b exp %b", lamps(), L_MG);
      end
      reset = 1'b1;
      sensor_sync = 1'b0;
      run_while(MAIN_MASK, MAIN_G, n, b);
      checks++;
      if (n !== 48) begin
         errors++;
         $display("FAIL reset_restores_base got %0d exp 48", n);
      end
   endtask

   task automatic test_random();
      restart();
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 999) == 0) begin
            reset = 1'b0;
            model_reset();
            #1;
            reset = 1'b1;
         end
         if ($urandom_range(0, 19) == 0) sensor_sync = 1'($urandom_range(0, 1));
         wr_sync    = ($urandom_range(0, 49) == 0);
         prog_sync  = ($urandom_range(0, 199) == 0);
         time_sel   = 2'($urandom_range(0, 3));
         time_value = TW'($urandom_range(0, 15));
         step();
         checks++;
         if (lamps() !== model_lamps()) begin
            errors++;
            $display("FAIL random_cycle%0d got %b exp %b", i, lamps(), model_lamps());
         end
      end
      wr_sync = 1'b0;
      prog_sync = 1'b0;
      sensor_sync = 1'b0;
   endtask

   initial begin
      test_reset();
      test_idle();
      test_sensor();
      test_walk();
      test_prog();
      test_prog_none();
      test_reset_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
